// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: datapath word, stage control word and the
// pipeline controller state encoding.
package lc3b_types;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned STALL_W = 16;

    typedef logic [WORD_W-1:0] lc3b_word;

    // Control word carried through ID/EX, EX/MEM and MEM/WB; all-zero is a bubble.
    typedef struct packed {
        logic [3:0] opcode;
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
    } lc3b_control_word;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at all-ones instead of wrapping.
// Ports: clk, reset (async, active-high), inc (count enable), count (value).
module sat_counter16
    import lc3b_types::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [STALL_W-1:0] count
);

    localparam logic [STALL_W-1:0] COUNT_MAX = {STALL_W{1'b1}};

    // Increment unless already saturated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + STALL_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: issues I/D cache requests, advances all stage
// registers together when both memories are satisfied ("step"), and
// handles load-use bubbles and taken-branch flushes.
// Ports: clk, reset (async, active-high); icache_resp, dcache_resp,
// mem_is_load, mem_is_store, load_use_hazard, branch_taken (inputs);
// icache_read, dcache_read, dcache_write, pc_load, *_advance, *_flush,
// stall_count (outputs, combinational except stall_count).
module pipe_ctrl
    import lc3b_types::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               icache_resp,
    input  logic               dcache_resp,
    input  logic               mem_is_load,
    input  logic               mem_is_store,
    input  logic               load_use_hazard,
    input  logic               branch_taken,
    output logic               icache_read,
    output logic               dcache_read,
    output logic               dcache_write,
    output logic               pc_load,
    output logic               ifid_advance,
    output logic               idex_advance,
    output logic               exmem_advance,
    output logic               memwb_advance,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               exmem_flush,
    output logic [STALL_W-1:0] stall_count
);

    pipe_state_t state, state_next;
    logic        i_done, i_done_next;
    logic        d_done, d_done_next;
    logic        run, d_need, step;

    // State and completion-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_INIT;
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            state  <= state_next;
            i_done <= i_done_next;
            d_done <= d_done_next;
        end
    end

    // Next state, flag update, requests and stage enables.
    always_comb begin
        state_next    = state;
        i_done_next   = i_done;
        d_done_next   = d_done;
        icache_read   = 1'b0;
        dcache_read   = 1'b0;
        dcache_write  = 1'b0;
        pc_load       = 1'b0;
        ifid_advance  = 1'b0;
        idex_advance  = 1'b0;
        exmem_advance = 1'b0;
        memwb_advance = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;

        run    = (state == S_RUN);
        d_need = mem_is_load | mem_is_store;
        // Responses count in the cycle they arrive, so step is same-cycle.
        step   = run & (i_done | icache_resp) & (~d_need | d_done | dcache_resp);

        case (state)
            S_INIT: state_next = S_RUN;
            S_RUN:  state_next = S_RUN;
            default: state_next = S_INIT;
        endcase

        if (run) begin
            icache_read  = ~i_done;
            dcache_read  = mem_is_load  & ~d_done;
            dcache_write = mem_is_store & ~d_done;
        end

        // A response only latches while its request is up; a step retires both.
        if (step) begin
            i_done_next = 1'b0;
            d_done_next = 1'b0;
        end else begin
            if (icache_read && icache_resp) begin
                i_done_next = 1'b1;
            end
            if ((dcache_read || dcache_write) && dcache_resp) begin
                d_done_next = 1'b1;
            end
        end

        if (step) begin
            idex_advance  = 1'b1;
            exmem_advance = 1'b1;
            memwb_advance = 1'b1;
            if (branch_taken) begin
                // Redirect wins over a load-use bubble: squash everything younger.
                pc_load      = 1'b1;
                ifid_advance = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                exmem_flush  = 1'b1;
            end else if (load_use_hazard) begin
                // Hold PC and IF/ID, insert a bubble into ID/EX.
                idex_flush   = 1'b1;
            end else begin
                pc_load      = 1'b1;
                ifid_advance = 1'b1;
            end
        end
    end

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (run & ~step),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of single-cycle vectors plus
// hand sequences for multi-cycle waits, mid-cycle reset and counter saturation.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        icache_resp, dcache_resp, mem_is_load, mem_is_store;
    logic        load_use_hazard, branch_taken;
    logic        icache_read, dcache_read, dcache_write, pc_load;
    logic        ifid_advance, idex_advance, exmem_advance, memwb_advance;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [15:0] stall_count;

    pipe_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .icache_resp     (icache_resp),
        .dcache_resp     (dcache_resp),
        .mem_is_load     (mem_is_load),
        .mem_is_store    (mem_is_store),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .icache_read     (icache_read),
        .dcache_read     (dcache_read),
        .dcache_write    (dcache_write),
        .pc_load         (pc_load),
        .ifid_advance    (ifid_advance),
        .idex_advance    (idex_advance),
        .exmem_advance   (exmem_advance),
        .memwb_advance   (memwb_advance),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {icache_resp, dcache_resp, mem_is_load, mem_is_store, load_use_hazard, branch_taken}
    // exp = {icache_read, dcache_read, dcache_write, pc_load, ifid_adv, idex_adv,
    //        exmem_adv, memwb_adv, ifid_flush, idex_flush, exmem_flush}
    typedef struct {
        logic [5:0]  in;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        logic [10:0] outs;
        logic [15:0] stall;
    } sb_t;

    sb_t         sbq[$];
    vec_t        vecs[16];
    int          checks;
    int          errors;
    logic [15:0] exp_stall;
    logic        in_run;

    function automatic logic [10:0] outs_now();
        return {icache_read, dcache_read, dcache_write, pc_load, ifid_advance,
                idex_advance, exmem_advance, memwb_advance,
                ifid_flush, idex_flush, exmem_flush};
    endfunction

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check11(input string nm, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {icache_resp, dcache_resp, mem_is_load, mem_is_store, load_use_hazard, branch_taken} = in;
    endtask

    // Called at a negedge; drives one cycle, checks before the posedge, returns at next negedge.
    task automatic apply(input string nm, input logic [5:0] in, input logic [10:0] exp);
        sb_t e;
        sb_t got;
        drive(in);
        e.outs  = exp;
        e.stall = exp_stall;
        sbq.push_back(e);
        #4;
        got = sbq.pop_front();
        check11({nm, "_outs"}, outs_now(), got.outs);
        check16({nm, "_stall"}, stall_count, got.stall);
        @(posedge clk);
        if (in_run && !exp[5] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        in_run = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 16'd0;
        in_run    = 1'b0;
        reset     = 1'b1;
        drive(6'b000000);

        vecs[0]  = '{6'b111000, 11'b000_00000_000}; // init cycle ignores everything
        vecs[1]  = '{6'b100000, 11'b100_11111_000};
        vecs[2]  = '{6'b100000, 11'b100_11111_000};
        vecs[3]  = '{6'b000000, 11'b100_00000_000};
        vecs[4]  = '{6'b010000, 11'b100_00000_000}; // unrequested dcache_resp
        vecs[5]  = '{6'b101000, 11'b110_00000_000};
        vecs[6]  = '{6'b001000, 11'b010_00000_000};
        vecs[7]  = '{6'b011000, 11'b010_11111_000};
        vecs[8]  = '{6'b110100, 11'b101_11111_000}; // both resps together
        vecs[9]  = '{6'b100010, 11'b100_00111_010}; // load-use
        vecs[10] = '{6'b100011, 11'b100_11111_111}; // branch over load-use
        vecs[11] = '{6'b000011, 11'b100_00000_000}; // no step, no flush
        vecs[12] = '{6'b010100, 11'b101_00000_000};
        vecs[13] = '{6'b000100, 11'b100_00000_000};
        vecs[14] = '{6'b100100, 11'b100_11111_000};
        vecs[15] = '{6'b100001, 11'b100_11111_111};

        repeat (2) @(negedge clk);
        check11("reset_outs", outs_now(), 11'b0);
        check16("reset_stall", stall_count, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
        end

        // Load with fetch done at cycle 0 and data at cycle 3.
        begin
            logic [15:0] base;
            base = exp_stall;
            apply("ld_c0", 6'b101000, 11'b110_00000_000);
            apply("ld_c1", 6'b001000, 11'b010_00000_000);
            apply("ld_c2", 6'b001000, 11'b010_00000_000);
            apply("ld_c3", 6'b011000, 11'b010_11111_000);
            check16("ld_stall_delta", stall_count - base, 16'd3);
        end

        // Reset between edges while waiting with i_done already set.
        apply("pre_rst", 6'b101000, 11'b110_00000_000);
        drive(6'b001000);
        #2 reset = 1'b1;
        #1;
        check11("midrst_req", {icache_read, dcache_read, dcache_write}, 3'b000);
        check16("midrst_stall", stall_count, 16'd0);
        @(negedge clk);
        reset     = 1'b0;
        in_run    = 1'b0;
        exp_stall = 16'd0;
        apply("post_init", 6'b111000, 11'b000_00000_000);
        apply("post_fresh", 6'b000000, 11'b100_00000_000);
        apply("post_step", 6'b100000, 11'b100_11111_000);

        // Saturation of the stall counter.
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        in_run    = 1'b0;
        exp_stall = 16'd0;
        apply("sat_init", 6'b000000, 11'b000_00000_000);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check16("sat_fffe", stall_count, 16'hFFFE);
        exp_stall = 16'hFFFE;
        apply("sat_a", 6'b000000, 11'b100_00000_000);
        apply("sat_b", 6'b000000, 11'b100_00000_000);
        apply("sat_c", 6'b000000, 11'b100_00000_000);
        check16("sat_hold", stall_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
